// File: rtl/reg_file_loader.sv
// reg_file_loader: streams 2**ADDR_WIDTH bytes into the register file, then reads them back against a shadow copy
module reg_file_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [ADDR_WIDTH-1:0] WRITEREG,
  output logic                  WRITEENABLE,
  output logic [ADDR_WIDTH-1:0] READREG1,
  input  logic [DATA_WIDTH-1:0] REGOUT1,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ADDR_WIDTH-1:0] ERRADDR
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_VERIFY, S_DONE} state_t;
  state_t st, nxt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] shadow [2**ADDR_WIDTH];
  logic hs;
  assign hs = (st == S_LOAD) && DIN_VALID;
  assign DIN_READY = (st == S_LOAD);
  assign BUSY = (st == S_LOAD) || (st == S_SETTLE) || (st == S_VERIFY);
  assign DONE = (st == S_DONE);
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:   nxt = START ? S_LOAD : S_IDLE;
      S_LOAD:   nxt = (hs && &idx) ? S_SETTLE : S_LOAD;
      S_SETTLE: nxt = S_VERIFY;
      S_VERIFY: nxt = &READREG1 ? S_DONE : S_VERIFY;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st          <= S_IDLE;
      idx         <= '0;
      WRITEDATA   <= '0;
      WRITEREG    <= '0;
      WRITEENABLE <= 1'b0;
      READREG1    <= '0;
      ERROR       <= 1'b0;
      ERRADDR     <= '0;
    end else begin
      st          <= nxt;
      WRITEENABLE <= hs;
      if (st == S_IDLE && START) begin
        idx     <= '0;
        ERROR   <= 1'b0;
        ERRADDR <= '0;
      end
      if (hs) begin
        WRITEDATA <= DIN;
        WRITEREG  <= idx;
        idx       <= idx + 1'b1;
      end
      if (st == S_SETTLE) READREG1 <= '0;
      // only the first mismatch is recorded; READREG1 wraps to 0 after the last compare
      if (st == S_VERIFY) begin
        READREG1 <= READREG1 + 1'b1;
        if (REGOUT1 != shadow[READREG1] && !ERROR) begin
          ERROR   <= 1'b1;
          ERRADDR <= READREG1;
        end
      end
    end
  end
  always_ff @(posedge CLK)
    if (hs) shadow[idx] <= DIN;
endmodule

// File: tb/tb_reg_file_loader.sv
// tb_reg_file_loader: scoreboard bench with a behavioural register file model
module tb_reg_file_loader;
  logic CLK = 1'b0;
  logic RESET, START, DIN_VALID, DIN_READY, WRITEENABLE, BUSY, DONE, ERROR;
  logic [7:0] DIN, WRITEDATA, REGOUT1;
  logic [2:0] WRITEREG, READREG1, ERRADDR;
  logic [7:0] rf [8];
  logic rf_rst;
  logic [7:0] corrupt;
  logic [10:0] wq [$];
  logic [10:0] wexp;
  int checks = 0, fails = 0, wcnt = 0;
  typedef struct {int cyc; logic err; logic [2:0] addr;} res_t;
  res_t rq [$];

  reg_file_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY), .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .READREG1(READREG1), .REGOUT1(REGOUT1),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERRADDR(ERRADDR)
  );

  always #5 CLK = ~CLK;

  assign REGOUT1 = rf[READREG1] ^ (corrupt[READREG1] ? 8'hFF : 8'h00);
  always @(posedge CLK)
    if (rf_rst) for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    else if (WRITEENABLE) rf[WRITEREG] <= WRITEDATA;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge CLK)
    if (WRITEENABLE) begin
      wcnt++;
      if (wq.size() == 0) chk("we_spurious", 1, 0);
      else begin
        wexp = wq.pop_front();
        chk("wreg", int'(WRITEREG), int'(wexp[10:8]));
        chk("wdata", int'(WRITEDATA), int'(wexp[7:0]));
      end
    end

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, DIN_READY, 0);
    chk({tag, "_wdata"}, WRITEDATA, 0);
    chk({tag, "_wreg"}, WRITEREG, 0);
    chk({tag, "_we"}, WRITEENABLE, 0);
    chk({tag, "_rreg"}, READREG1, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_err"}, ERROR, 0);
    chk({tag, "_erraddr"}, ERRADDR, 0);
  endtask

  task automatic run_seq(input logic [7:0] base, input logic [7:0] step, input bit stall,
                         input logic [7:0] cm, input int s2, input int rr,
                         input int ec, input logic ee, input logic [2:0] ea);
    int cyc = 0, k = 0;
    res_t r;
    corrupt = cm;
    wcnt = 0;
    rq.push_back('{ec, ee, ea});
    @(negedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    chk("start_clr_err", ERROR, 0);
    chk("busy_start", BUSY, 1);
    while (!DONE && cyc < 100) begin
      @(negedge CLK); #1;
      if ((!stall || cyc % 2 == 0) && k < 8) begin
        DIN = 8'(base + step * k);
        DIN_VALID = 1'b1;
        if (DIN_READY) begin
          wq.push_back({k[2:0], DIN});
          k++;
        end
      end else DIN_VALID = 1'b0;
      START = (cyc == s2);
      rf_rst = (cyc == rr);
      @(posedge CLK); #1 cyc++;
    end
    DIN_VALID = 1'b0;
    START = 1'b0;
    rf_rst = 1'b0;
    r = rq.pop_front();
    if (!DONE) chk("done_timeout", 0, 1);
    chk("done_cyc", cyc, r.cyc);
    chk("error", ERROR, int'(r.err));
    if (r.err) chk("erraddr", ERRADDR, int'(r.addr));
    chk("busy_at_done", BUSY, 0);
    chk("wcount", wcnt, 8);
    @(posedge CLK); #1;
    chk("done_pulse", DONE, 0);
    chk("error_hold", ERROR, int'(r.err));
    if (r.err) chk("erraddr_hold", ERRADDR, int'(r.addr));
    corrupt = 8'h00;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; DIN_VALID = 1'b0; DIN = 8'h00; rf_rst = 1'b0; corrupt = 8'h00;
    repeat (2) @(posedge CLK);
    #1 chk_zero("reset");
    RESET = 1'b0;
    // idle ignores the stream
    @(negedge CLK); #1 DIN_VALID = 1'b1; DIN = 8'h55;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("idle_ready", DIN_READY, 0);
      chk("idle_we", WRITEENABLE, 0);
    end
    DIN_VALID = 1'b0;
    run_seq(8'd10, 8'd10, 1'b0, 8'h00, -1, -1, 17, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) chk("rf_content", rf[i], 10 * (i + 1));
    run_seq(8'hA0, 8'd1, 1'b1, 8'h00, -1, -1, 24, 1'b0, 3'd0);
    run_seq(8'h31, 8'd7, 1'b0, 8'h60, -1, -1, 17, 1'b1, 3'd5);
    run_seq(8'h05, 8'd3, 1'b0, 8'h00, -1, -1, 17, 1'b0, 3'd0);
    run_seq(8'h11, 8'd2, 1'b0, 8'h00, 12, -1, 17, 1'b0, 3'd0);
    // abandon a load after three bytes
    @(negedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      DIN = 8'(8'hC0 + i);
      DIN_VALID = 1'b1;
      wq.push_back({3'(i), DIN});
      @(posedge CLK); #1;
    end
    @(negedge CLK); #1 DIN_VALID = 1'b0; RESET = 1'b1;
    @(posedge CLK); #1 chk_zero("midreset");
    RESET = 1'b0;
    wq.delete();
    run_seq(8'h21, 8'd1, 1'b0, 8'h00, -1, -1, 17, 1'b0, 3'd0);
    run_seq(8'h40, 8'd1, 1'b0, 8'h00, -1, 10, 17, 1'b1, 3'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_loader.md
# reg_file_loader

Initiator-side sequencer for the 8×8-bit register file. It accepts eight bytes over a valid/ready stream and writes them to registers 0..7 through the file's write port. It then reads each register back through read port 1 and compares it against a shadow copy. The bench and boot logic use it to preload the register file and self-check it before the CPU datapath takes the ports.

## Interface
Parameters:
- DATA_WIDTH, 8, width of a register and of the input stream
- ADDR_WIDTH, 3, register address width; the block always loads 2**ADDR_WIDTH registers

Ports:
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  synchronous, active-high reset (sampled on posedge CLK)
- START  in  1  begin a load/verify sequence; honoured only in IDLE
- DIN  in  DATA_WIDTH  stream byte
- DIN_VALID  in  1  DIN holds a valid byte
- DIN_READY  out  1  block can accept a byte; high only in LOAD
- WRITEDATA  out  DATA_WIDTH  to register file IN
- WRITEREG  out  ADDR_WIDTH  to register file INADDRESS
- WRITEENABLE  out  1  to register file WRITE
- READREG1  out  ADDR_WIDTH  to register file OUT1ADDRESS
- REGOUT1  in  DATA_WIDTH  from register file OUT1
- BUSY  out  1  high in LOAD, SETTLE and VERIFY
- DONE  out  1  one-cycle pulse when the sequence ends
- ERROR  out  1  sticky mismatch flag; cleared on RESET or accepted START
- ERRADDR  out  ADDR_WIDTH  address of the first mismatch; valid while ERROR=1

## Operation
- States: IDLE, LOAD, SETTLE, VERIFY, DONE.
- IDLE:
  - START=1 → LOAD, with idx=0 and ERROR/ERRADDR cleared.
  - DIN_VALID is ignored.
- LOAD:
  - DIN_READY=1 (decoded from state).
  - On each handshake (DIN_VALID & DIN_READY at a posedge): WRITEDATA←DIN, WRITEREG←idx, WRITEENABLE←1, shadow[idx]←DIN, idx←idx+1.
  - Without a handshake, WRITEENABLE←0.
  - The handshake at idx=7 → SETTLE.
- SETTLE: exactly one cycle. The last write is presented and committed by the register file. WRITEENABLE←0, READREG1←0 → VERIFY.
- VERIFY:
  - At each posedge, compare REGOUT1 with shadow[READREG1].
  - On a mismatch with ERROR=0: ERROR←1, ERRADDR←READREG1. Later mismatches leave ERRADDR unchanged.
  - READREG1←READREG1+1.
  - The compare of address 7 → DONE, with READREG1 wrapping to 0.
- DONE: DONE=1 for one cycle → IDLE. ERROR and ERRADDR hold until the next accepted START or RESET.
- WRITEENABLE is registered. It is high for exactly one cycle per accepted byte, so back-to-back handshakes give a continuous high with WRITEREG incrementing 0..7.
- START outside IDLE is ignored, including during the DONE cycle.
- The shadow buffer is not reset. It is only read after all eight entries have been written in the current sequence.
- The block never drives the register file's RESET. A register-file reset during a sequence shows up as verify mismatches.

## Timing
- Reset values: DIN_READY 0, WRITEDATA 0, WRITEREG 0, WRITEENABLE 0, READREG1 0, BUSY 0, DONE 0, ERROR 0, ERRADDR 0; state IDLE, idx 0.
- RESET mid-sequence: at the next posedge all of the above are restored and the sequence is abandoned. A partially loaded register file is left as-is.
- Cycle counts, with START sampled at posedge t0:
  - Handshakes are possible at t1 onward.
  - With DIN_VALID held high, bytes are accepted at t1..t8. SETTLE is t8→t9, VERIFY compares at t10..t17, DONE is high t17→t18.
  - DONE rises 17 cycles after t0, plus one cycle per LOAD cycle without a handshake.
- Read timing: READREG1 changes at a posedge and REGOUT1 is sampled at the next posedge. This requires the register file read delay plus write-to-read delay to be less than one CLK period.
- BUSY falls on the same edge DONE rises.

## Test plan
- **Clean run:** RESET, then START with DIN=10,20,…,80 and DIN_VALID held high → WRITEENABLE high 8 consecutive cycles with WRITEREG 0..7. DONE pulses 17 cycles after START. ERROR=0, and registers 0..7 hold 10..80.
- **Stalled stream:** DIN_VALID toggled 1,0,1,0… with DIN=0xA0+idx → exactly 8 write pulses, none in stall cycles. DONE 24 cycles after START. ERROR=0.
- **Mismatch:** the bench model corrupts REGOUT1 for addresses 5 and 6 → ERROR=1 and ERRADDR=5 at DONE, holding afterwards. A following clean START clears ERROR at its start edge and ends with ERROR=0.
- **Ignored inputs:** DIN_VALID=1 in IDLE → DIN_READY=0 and no WRITEENABLE. A second START during VERIFY → no restart, and DONE still arrives at the nominal cycle.
- **Reset mid-load:** RESET after 3 handshakes → next posedge all outputs 0 and BUSY=0. A new START writes from WRITEREG=0 again and completes with ERROR=0.
- **Register-file reset interference:** pulse the register file's RESET during VERIFY before address 2 is compared → ERROR=1 and ERRADDR=2, given nonzero loaded data.
